// File: rtl/mm_pkg.sv
// mm_pkg: shared constants and types for the matrix-multiply engine.
// Line/address widths are shared with the feature-address generator.
package mm_pkg;

    localparam int LINE_W     = 512;
    localparam int LADDR_W    = 11;
    localparam int FBUF_DEPTH = 2048;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fbuf_state_t;

endpackage

// File: rtl/mm_fbuf_ram.sv
// mm_fbuf_ram: simple dual-port line RAM, registered read, read-first.
// The array has no reset; only the clear sequence zeroes it.
import mm_pkg::*;

module mm_fbuf_ram #(
    parameter int DATA_W = LINE_W,
    parameter int AW     = LADDR_W,
    parameter int DEPTH  = FBUF_DEPTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // One write port and one registered read port; same-edge read sees old data
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/mm_fbuf.sv
// mm_fbuf: feature line buffer with fixed read latency and hardware clear.
// MM_FBUF_BYPASS_EN: forward same-edge write data to a same-address read.
import mm_pkg::*;

module mm_fbuf #(
    parameter int DATA_W = LINE_W,
    parameter int ADDR_W = LADDR_W,
    parameter int DEPTH  = FBUF_DEPTH,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              addr_input_valid,
    input  logic [ADDR_W-1:0] addr_input,
    output logic              input_data_valid,
    output logic [DATA_W-1:0] input_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_start,
    output logic              ready,
    output logic              addr_err
);

    localparam int RAW = $clog2(DEPTH);
    localparam int NP  = RD_LAT - 1;

    fbuf_state_t       state;
    logic [RAW-1:0]    cnt;
    logic              clearing;
    logic              rd_oor;
    logic              wr_oor;
    logic              ram_we;
    logic              ram_re;
    logic [RAW-1:0]    ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              v1;
    logic              z1;
    logic [DATA_W-1:0] s1_data;
    logic [NP-1:0]     vq;
    logic [DATA_W-1:0] dq [NP];

    assign clearing = (state == CLEAR);
    assign rd_oor   = {1'b0, addr_input} >= (ADDR_W+1)'(DEPTH);
    assign wr_oor   = {1'b0, wr_addr} >= (ADDR_W+1)'(DEPTH);

    // Clear owns the write port; external writes are dropped meanwhile
    assign ram_we    = clearing | (wr_valid & ~wr_oor);
    assign ram_waddr = clearing ? cnt : wr_addr[RAW-1:0];
    assign ram_wdata = clearing ? '0 : wr_data;
    assign ram_re    = addr_input_valid & ~rd_oor & ~clearing;

    mm_fbuf_ram #(
        .DATA_W (DATA_W),
        .AW     (RAW),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .re     (ram_re),
        .raddr  (addr_input[RAW-1:0]),
        .rdata  (ram_rdata)
    );

    // Clear FSM: zero one line per cycle, ready low for the whole sweep
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (cnt == RAW'(DEPTH - 1)) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + RAW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flag for any read or write outside the buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            addr_err <= 1'b0;
        else if ((addr_input_valid & rd_oor) | (wr_valid & wr_oor))
            addr_err <= 1'b1;
    end

    // Stage 1 side-band: valid and force-zero travel beside the RAM read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1 <= 1'b0;
            z1 <= 1'b0;
        end else begin
            v1 <= addr_input_valid;
            z1 <= rd_oor | clearing;
        end
    end

`ifdef MM_FBUF_BYPASS_EN
    logic              byp1;
    logic [DATA_W-1:0] wd1;

    // Capture a same-edge same-address write for write-first forwarding
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byp1 <= 1'b0;
            wd1  <= '0;
        end else begin
            byp1 <= addr_input_valid & wr_valid & ~wr_oor & ~clearing
                  & (wr_addr == addr_input);
            wd1  <= wr_data;
        end
    end

    // Stage 1 result: zero, forwarded write data, or RAM contents
    always_comb begin
        s1_data = ram_rdata;
        if (byp1)
            s1_data = wd1;
        if (z1)
            s1_data = '0;
    end
`else
    // Stage 1 result: zero or RAM contents
    always_comb begin
        s1_data = ram_rdata;
        if (z1)
            s1_data = '0;
    end
`endif

    // Output register plus delay stages up to RD_LAT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vq <= '0;
            for (int i = 0; i < NP; i++)
                dq[i] <= '0;
        end else begin
            vq[0] <= v1;
            dq[0] <= s1_data;
            for (int i = 1; i < NP; i++) begin
                vq[i] <= vq[i-1];
                dq[i] <= dq[i-1];
            end
        end
    end

    assign input_data_valid = vq[NP-1];
    assign input_data       = dq[NP-1];

endmodule

// File: tb/tb_mm_fbuf.sv
// tb_mm_fbuf: scoreboard bench for mm_fbuf with a line-memory model.
// Build with MM_FBUF_BYPASS_EN to expect write-first forwarding.
module tb_mm_fbuf;

    localparam int DW  = 512;
    localparam int AW  = 12;
    localparam int DEP = 2048;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          addr_input_valid = 1'b0;
    logic [AW-1:0] addr_input = '0;
    logic          input_data_valid;
    logic [DW-1:0] input_data;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clear_start = 1'b0;
    logic          ready;
    logic          addr_err;

    exp_t          sbq[$];
    logic [DW-1:0] mem [DEP];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            clr_left = 0;
    logic          err_m = 1'b0;
    int            nlow;

    mm_fbuf #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEP),
        .RD_LAT (2)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .addr_input_valid (addr_input_valid),
        .addr_input       (addr_input),
        .input_data_valid (input_data_valid),
        .input_data       (input_data),
        .wr_valid         (wr_valid),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .clear_start      (clear_start),
        .ready            (ready),
        .addr_err         (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, update model, check outputs at next negedge
    task automatic step(input logic rv, input logic [AW-1:0] ra,
                        input logic wv, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic cs);
        logic          in_clr;
        logic [DW-1:0] ed;
        exp_t          e;
        in_clr = (clr_left > 0);
        addr_input_valid = rv;
        addr_input       = ra;
        wr_valid         = wv;
        wr_addr          = wa;
        wr_data          = wd;
        clear_start      = cs;
        if (rv) begin
            if (ra >= DEP || in_clr)
                ed = '0;
            else
                ed = mem[ra[10:0]];
`ifdef MM_FBUF_BYPASS_EN
            if (wv && wa == ra && ra < DEP && !in_clr)
                ed = wd;
`endif
            e.data = ed;
            e.due  = cyc + 2;
            sbq.push_back(e);
        end
        if ((rv && ra >= DEP) || (wv && wa >= DEP))
            err_m = 1'b1;
        if (wv && wa < DEP && !in_clr)
            mem[wa[10:0]] = wd;
        if (in_clr) begin
            clr_left--;
        end else if (cs) begin
            clr_left = DEP;
            for (int i = 0; i < DEP; i++)
                mem[i] = '0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (input_data_valid) begin
            if (sbq.size() == 0) begin
                check("spurious_valid", 1'b1, 1'b0);
            end else begin
                e = sbq.pop_front();
                check("rd_data", input_data, e.data);
                check("rd_cycle", cyc, e.due);
            end
        end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
            check("rd_missing", 1'b0, 1'b1);
            void'(sbq.pop_front());
        end
        check("ready", ready, clr_left == 0);
        check("addr_err", addr_err, err_m);
        addr_input_valid = 1'b0;
        wr_valid         = 1'b0;
        clear_start      = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b0, '0, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b1, a, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        repeat (4) idle();
    endtask

    initial begin
        for (int i = 0; i < DEP; i++)
            mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", input_data_valid, 1'b0);
        check("rst_data", input_data, '0);
        check("rst_ready", ready, 1'b1);
        check("rst_err", addr_err, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        wr(12'd5, {64{8'hA5}});
        idle();
        rd(12'd5);
        drain();

        for (int i = 0; i < 16; i++)
            wr(AW'(i), DW'(i));
        for (int i = 0; i < 16; i++)
            rd(AW'(i));
        drain();

        wr(12'd7, DW'(32'h99));
        idle();
        step(1'b1, 12'd7, 1'b1, 12'd7, DW'(32'h1234), 1'b0);
        rd(12'd7);
        drain();

        wr(12'd2047, {16{32'hC0DE_2047}});
        idle();
        rd(12'd2047);
        rd(12'd2048);
        drain();
        check("err_sticky", addr_err, 1'b1);

        wr(12'd9, DW'(32'h77));
        idle();
        step(1'b0, '0, 1'b1, 12'd9, DW'(32'h55), 1'b1);
        nlow = ready ? 0 : 1;
        step(1'b1, 12'd9, 1'b1, 12'd3, DW'(32'h33), 1'b0);
        nlow += ready ? 0 : 1;
        step(1'b1, 12'd10, 1'b0, '0, '0, 1'b1);
        nlow += ready ? 0 : 1;
        for (int i = 0; i < 3000 && !ready; i++) begin
            idle();
            nlow += ready ? 0 : 1;
        end
        check("clear_len", nlow, DEP);
        rd(12'd3);
        rd(12'd9);
        wr(12'd4, DW'(32'h4444));
        rd(12'd4);
        drain();

        wr(12'd20, DW'(32'hBEEF));
        idle();
        rd(12'd20);
        rd(12'd20);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", input_data_valid, 1'b0);
        check("mid_rst_data", input_data, '0);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_err", addr_err, 1'b0);
        sbq.delete();
        err_m = 1'b0;
        clr_left = 0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) idle();
        rd(12'd20);
        drain();

        check("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
